module_calc_core: RTL and testbench
===================================

# module_calc_core

Parametrised successor to the single-operand decimal adder in the calculator datapath. It takes one-shot key codes from the keypad decoder and handles multi-digit operand entry with backspace, chained signed addition and subtraction, and saturating overflow. A sequential binary-to-BCD converter (double-dabble, one bit per clock) produces the digits that drive the 7-segment display multiplexer.

## Interface
- NUM_DIGITS, 4, decimal digits per operand/result; magnitude cap RESULT_MAX = 10^NUM_DIGITS.
- RESULT_WIDTH, 14, binary magnitude width; must satisfy 2^RESULT_WIDTH > RESULT_MAX-1 (elaboration error otherwise).
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- key_code  in  4  0..9 digit, 10 ADD, 11 EQUAL, 12 CLEAR, 13 SUB, 14 BACKSPACE, 15 ignored.
- key_pulse  in  1  one-clock strobe qualifying key_code.
- result  out  RESULT_WIDTH  magnitude of running total.
- result_neg  out  1  sign of total; always 0 when result==0.
- result_valid  out  1  level: total is current (last key ADD/SUB/EQUAL).
- result_pulse  out  1  one-clock strobe, the cycle after an ADD/SUB/EQUAL edge.
- overflow  out  1  sticky saturation flag.
- disp_bcd  out  4*NUM_DIGITS  BCD of displayed magnitude, digit 0 in [3:0].
- disp_neg  out  1  minus-sign segment for the display.
- bcd_valid  out  1  disp_bcd matches current displayed value.
- busy  out  1  converter running.

## Operation
- Registers: total (magnitude + sign), curr (magnitude), op_reg (ADD/SUB, reset ADD), show_total, eq_done.
- Digit d: if eq_done, total←0 (+), op_reg←ADD, eq_done←0 first. Then tmp = curr*10+d, using RESULT_WIDTH+4 bits. If tmp < RESULT_MAX, curr←tmp; otherwise the digit is ignored with no overflow. show_total←0, result_valid←0.
- BACKSPACE: curr←curr/10 (integer). Ignored when eq_done=1. show_total←0, result_valid←0.
- ADD/SUB/EQUAL: apply op_reg to the signed values total and curr, using RESULT_WIDTH+2-bit signed arithmetic.
  - If |sum| ≥ RESULT_MAX: magnitude saturates to RESULT_MAX-1, sign kept, overflow←1.
  - Zero result forces sign +.
  - Then: curr←0; show_total←1; result_valid←1; result_pulse next cycle.
  - ADD/SUB also set op_reg to the key's operator and clear eq_done. EQUAL sets op_reg←ADD and eq_done←1.
- CLEAR: every register returns to its reset value, including overflow; a conversion of 0 starts.
- key_code 15 or key_pulse low: no change.
- Displayed value = show_total ? total : curr. disp_neg = show_total & result_neg.
- Converter FSM has three states: IDLE, LOAD, SHIFT.
  - Any accepted key (codes 0..14) sets conv_req on the same edge.
  - LOAD: capture displayed value, clear the BCD scratch, cnt←RESULT_WIDTH, go to SHIFT.
  - SHIFT: each cycle add 3 to every BCD nibble ≥5, then shift left 1. At cnt==1, write disp_bcd, set bcd_valid←1, go to IDLE.
  - conv_req seen in any state forces LOAD next cycle, aborting any conversion in progress. bcd_valid←0 from the key edge until completion.
- busy=1 in LOAD and SHIFT.

## Timing
- Reset and CLEAR values:
  - result=0, result_neg=0, result_valid=0, result_pulse=0, overflow=0.
  - disp_bcd=0, disp_neg=0, bcd_valid=1, busy=0.
  - The reset state needs no conversion. CLEAR still runs one.
- Arithmetic registers, result_valid and overflow update on the edge that samples key_pulse=1 (edge k).
- result_pulse is high during cycle k..k+1 only.
- Converter: bcd_valid low after edge k, LOAD at edge k+1, shifts at edges k+2..k+1+RESULT_WIDTH. disp_bcd/bcd_valid update at edge k+1+RESULT_WIDTH, so latency is RESULT_WIDTH+1 clocks (15 for defaults).
- A key during a conversion restarts the timing from the new edge. disp_bcd holds its old value until the new conversion completes.
- Back-to-back key_pulse every cycle is legal; each key is processed.
- rst mid-conversion: the converter returns to IDLE on that edge with reset outputs.

## Test plan
- Defaults; keys 1,2,ADD,3,4,EQUAL -> result=46, result_neg=0, result_pulse twice, disp_bcd=16'h0046 and bcd_valid 15 clocks after EQUAL.
- Keys 5,SUB,8,EQUAL -> result=3, result_neg=1, disp_neg=1, disp_bcd=16'h0003. Then 3,ADD -> total=3+ with eq_done start: display shows curr 3; ADD gives result=3, result_neg=0.
- Keys 9,9,9,9,5 -> curr 9999 (5 ignored, overflow=0). Then ADD,1,EQUAL -> result=9999, overflow=1. Then CLEAR -> overflow=0, result=0.
- Keys 1,2,3,BACKSPACE -> display 12, bcd_valid=1. Then EQUAL, BACKSPACE -> ignored, result stays 12.
- Key 7 then key 8 two clocks later -> first conversion aborted, busy continuous, single bcd_valid rise with disp_bcd=16'h0078.
- rst asserted during SHIFT -> next cycle all outputs at reset values, busy=0, bcd_valid=1.

Source files
------------

// File: rtl/module_calc_core.sv
// rtl/module_calc_core.sv - keypad calculator core: operand entry, signed add/sub with saturation, BCD display
module module_calc_core #(
   parameter int NUM_DIGITS   = 4,
   parameter int RESULT_WIDTH = 14
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [3:0]                key_code,
   input  logic                      key_pulse,
   output logic [RESULT_WIDTH-1:0]   result,
   output logic                      result_neg,
   output logic                      result_valid,
   output logic                      result_pulse,
   output logic                      overflow,
   output logic [4*NUM_DIGITS-1:0]   disp_bcd,
   output logic                      disp_neg,
   output logic                      bcd_valid,
   output logic                      busy
);

   localparam int RESULT_MAX = 10 ** NUM_DIGITS;
   localparam int TW = RESULT_WIDTH + 4;
   localparam int SW = RESULT_WIDTH + 2;
   localparam int BW = 4 * NUM_DIGITS;
   localparam int CW = $clog2(RESULT_WIDTH + 1);
   localparam logic [TW-1:0]           MAX_T   = TW'(RESULT_MAX);
   localparam logic [RESULT_WIDTH-1:0] SAT_MAG = RESULT_WIDTH'(RESULT_MAX - 1);

   if ((2 ** RESULT_WIDTH) <= (RESULT_MAX - 1)) begin : g_width_check
      $error("RESULT_WIDTH too small to hold 10^NUM_DIGITS-1");
   end

   typedef enum logic [1:0] {C_IDLE, C_LOAD, C_SHIFT} conv_state_t;

   logic [RESULT_WIDTH-1:0] total_mag;
   logic                    total_neg;
   logic [RESULT_WIDTH-1:0] curr;
   logic                    op_sub;
   logic                    show_total;
   logic                    eq_done;

   logic key_acc, is_digit, is_op;
   assign key_acc  = key_pulse && (key_code != 4'd15);
   assign is_digit = (key_code <= 4'd9);
   assign is_op    = (key_code == 4'd10) || (key_code == 4'd11) || (key_code == 4'd13);

   logic [TW-1:0]           tmp;
   logic signed [SW-1:0]    tot_s, cur_s, sum_s;
   logic [SW-1:0]           sum_mag;
   logic [RESULT_WIDTH-1:0] new_mag;
   logic                    new_neg;
   logic                    sat;

   assign tmp = ({4'b0000, curr} * TW'(10)) + {{(TW-4){1'b0}}, key_code};

   always_comb begin
      tot_s = $signed({2'b00, total_mag});
      if (total_neg)
         tot_s = -tot_s;
      cur_s   = $signed({2'b00, curr});
      sum_s   = op_sub ? (tot_s - cur_s) : (tot_s + cur_s);
      sum_mag = sum_s[SW-1] ? $unsigned(-sum_s) : $unsigned(sum_s);
      sat     = ({2'b00, sum_mag} >= MAX_T);
      new_mag = sat ? SAT_MAG : sum_mag[RESULT_WIDTH-1:0];
      // a negative sum always has nonzero magnitude, so zero comes out positive
      new_neg = sum_s[SW-1];
   end

   always_ff @(posedge clk) begin
      if (rst || (key_acc && key_code == 4'd12)) begin
         total_mag    <= '0;
         total_neg    <= 1'b0;
         curr         <= '0;
         op_sub       <= 1'b0;
         show_total   <= 1'b0;
         eq_done      <= 1'b0;
         result_valid <= 1'b0;
         overflow     <= 1'b0;
         result_pulse <= 1'b0;
      end else begin
         result_pulse <= key_acc && is_op;
         if (key_acc && is_digit) begin
            if (eq_done) begin
               total_mag <= '0;
               total_neg <= 1'b0;
               op_sub    <= 1'b0;
               eq_done   <= 1'b0;
            end
            if (tmp < MAX_T)
               curr <= tmp[RESULT_WIDTH-1:0];
            show_total   <= 1'b0;
            result_valid <= 1'b0;
         end else if (key_acc && key_code == 4'd14) begin
            if (!eq_done) begin
               curr         <= curr / RESULT_WIDTH'(10);
               show_total   <= 1'b0;
               result_valid <= 1'b0;
            end
         end else if (key_acc && is_op) begin
            total_mag    <= new_mag;
            total_neg    <= new_neg;
            curr         <= '0;
            show_total   <= 1'b1;
            result_valid <= 1'b1;
            if (sat)
               overflow <= 1'b1;
            op_sub  <= (key_code == 4'd13);
            eq_done <= (key_code == 4'd11);
         end
      end
   end

   assign result     = total_mag;
   assign result_neg = total_neg;
   assign disp_neg   = show_total & total_neg;

   conv_state_t             state, state_nxt;
   logic                    conv_req;
   logic [CW-1:0]           cnt;
   logic [RESULT_WIDTH-1:0] bin_sr;
   logic [RESULT_WIDTH-1:0] disp_val;
   logic [BW-1:0]           bcd_sr, bcd_adj, bcd_nxt;

   assign disp_val = show_total ? total_mag : curr;

   always_ff @(posedge clk) begin
      if (rst)
         state <= C_IDLE;
      else
         state <= state_nxt;
   end

   // LOAD is entered with the operand already captured and performs the first shift
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         C_LOAD, C_SHIFT: begin
            busy      = 1'b1;
            state_nxt = (cnt == CW'(1)) ? C_IDLE : C_SHIFT;
         end
         default: state_nxt = C_IDLE;
      endcase
      if (conv_req)
         state_nxt = C_LOAD;
   end

   always_comb begin
      bcd_adj = bcd_sr;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_sr[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
      bcd_nxt = (bcd_adj << 1) | BW'(bin_sr[RESULT_WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         conv_req  <= 1'b0;
         cnt       <= '0;
         bin_sr    <= '0;
         bcd_sr    <= '0;
         disp_bcd  <= '0;
         bcd_valid <= 1'b1;
      end else begin
         conv_req <= key_acc;
         if (conv_req) begin
            bin_sr <= disp_val;
            bcd_sr <= '0;
            cnt    <= CW'(RESULT_WIDTH);
         end else if (busy) begin
            bin_sr <= bin_sr << 1;
            bcd_sr <= bcd_nxt;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               disp_bcd  <= bcd_nxt;
               bcd_valid <= 1'b1;
            end
         end
         if (key_acc)
            bcd_valid <= 1'b0;
         if (key_acc && key_code == 4'd12)
            disp_bcd <= '0;
      end
   end

endmodule

// File: tb/tb_module_calc_core.sv
// tb/tb_module_calc_core.sv - self-checking bench for module_calc_core against an integer reference model
module tb_module_calc_core;

   localparam int ND   = 4;
   localparam int RW   = 14;
   localparam int RMAX = 10000;
   localparam int LAT  = RW + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      key_code;
   logic            key_pulse;
   logic [RW-1:0]   result;
   logic            result_neg, result_valid, result_pulse, overflow;
   logic [4*ND-1:0] disp_bcd;
   logic            disp_neg, bcd_valid, busy;

   module_calc_core #(.NUM_DIGITS(ND), .RESULT_WIDTH(RW)) dut (
      .clk(clk), .rst(rst), .key_code(key_code), .key_pulse(key_pulse),
      .result(result), .result_neg(result_neg), .result_valid(result_valid),
      .result_pulse(result_pulse), .overflow(overflow), .disp_bcd(disp_bcd),
      .disp_neg(disp_neg), .bcd_valid(bcd_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference state: signed running total and plain integer operand
   int m_tot, m_curr, m_sub, m_show, m_eq, m_ovf, m_rv;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int to_bcd(input int v);
      int r = 0;
      for (int i = 0; i < ND; i++) begin
         r = r | ((v % 10) << (4 * i));
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int shown();
      return (m_show != 0) ? iabs(m_tot) : m_curr;
   endfunction

   task automatic model_reset();
      m_tot = 0; m_curr = 0; m_sub = 0; m_show = 0; m_eq = 0; m_ovf = 0; m_rv = 0;
   endtask

   task automatic model_key(input int k);
      int s;
      if (k <= 9) begin
         if (m_eq != 0) begin m_tot = 0; m_sub = 0; m_eq = 0; end
         if (m_curr * 10 + k < RMAX) m_curr = m_curr * 10 + k;
         m_show = 0; m_rv = 0;
      end else if (k == 14) begin
         if (m_eq == 0) begin m_curr = m_curr / 10; m_show = 0; m_rv = 0; end
      end else if (k == 12) begin
         model_reset();
      end else if (k == 10 || k == 11 || k == 13) begin
         s = (m_sub != 0) ? m_tot - m_curr : m_tot + m_curr;
         if (iabs(s) >= RMAX) begin
            s = (s < 0) ? -(RMAX - 1) : (RMAX - 1);
            m_ovf = 1;
         end
         m_tot = s; m_curr = 0; m_show = 1; m_rv = 1;
         m_sub = (k == 13) ? 1 : 0;
         m_eq  = (k == 11) ? 1 : 0;
      end
   endtask

   task automatic check_reset();
      check("rst_result", result, 0);
      check("rst_result_neg", result_neg, 0);
      check("rst_result_valid", result_valid, 0);
      check("rst_result_pulse", result_pulse, 0);
      check("rst_overflow", overflow, 0);
      check("rst_disp_bcd", disp_bcd, 0);
      check("rst_disp_neg", disp_neg, 0);
      check("rst_bcd_valid", bcd_valid, 1);
      check("rst_busy", busy, 0);
   endtask

   task automatic press(input int k);
      @(negedge clk);
      key_code  = 4'(k);
      key_pulse = 1'b1;
      @(posedge clk);
      model_key(k);
      #1;
      key_pulse = 1'b0;
      check("result", result, iabs(m_tot));
      check("result_neg", result_neg, (m_tot < 0) ? 1 : 0);
      check("result_valid", result_valid, m_rv);
      check("overflow", overflow, m_ovf);
      check("result_pulse", result_pulse, (k == 10 || k == 11 || k == 13) ? 1 : 0);
      check("disp_neg", disp_neg, (m_show != 0 && m_tot < 0) ? 1 : 0);
      if (k != 15)
         check("bcd_valid_low", bcd_valid, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         key_code  = 4'($urandom_range(0, 15));
         key_pulse = 1'b0;
         @(posedge clk);
         #1;
         check("pulse_idle", result_pulse, 0);
      end
   endtask

   // call directly after press(): counts edges from the key edge until bcd_valid rises
   task automatic wait_conv();
      int n    = 0;
      int gaps = 0;
      bit done = 1'b0;
      while (n < 40 && !done) begin
         @(posedge clk);
         #1;
         n++;
         if (bcd_valid) done = 1'b1;
         else if (!busy) gaps++;
      end
      check("conv_latency", n, LAT);
      check("busy_gap", gaps, 0);
      check("disp_bcd", disp_bcd, to_bcd(shown()));
      check("busy_end", busy, 0);
   endtask

   initial begin
      int r, k;
      rst = 1'b1; key_pulse = 1'b0; key_code = 4'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset();
      rst = 1'b0;

      // chained addition
      press(1); idle(1); press(2); press(10); press(3); press(4); press(11);
      check("t1_result", result, 46);
      wait_conv();
      check("t1_bcd", disp_bcd, 'h0046);

      // subtraction to negative, then fresh operand after EQUAL
      press(5); press(13); press(8); press(11);
      check("t2_result", result, 3);
      check("t2_neg", result_neg, 1);
      check("t2_disp_neg", disp_neg, 1);
      wait_conv();
      check("t2_bcd", disp_bcd, 'h0003);
      press(3);
      wait_conv();
      check("t2_bcd_curr", disp_bcd, 'h0003);
      press(10);
      check("t2_add_result", result, 3);
      check("t2_add_neg", result_neg, 0);

      // entry cap, saturation, clear
      press(9); press(9); press(9); press(9); press(5);
      wait_conv();
      check("t3_cap_bcd", disp_bcd, 'h9999);
      check("t3_no_ovf", overflow, 0);
      press(10); press(1); press(11);
      check("t3_sat_result", result, 9999);
      check("t3_ovf", overflow, 1);
      press(12);
      check("t3_clr_ovf", overflow, 0);
      check("t3_clr_result", result, 0);
      wait_conv();

      // backspace, and backspace ignored after EQUAL
      press(1); press(2); press(3); press(14);
      wait_conv();
      check("t4_bcd", disp_bcd, 'h0012);
      check("t4_bcd_valid", bcd_valid, 1);
      press(11); press(14);
      check("t4_result", result, 12);

      // conversion aborted by a second key
      press(12);
      wait_conv();
      press(7);
      idle(1);
      check("t5_busy", busy, 1);
      check("t5_bcd_valid", bcd_valid, 0);
      press(8);
      wait_conv();
      check("t5_bcd", disp_bcd, 'h0078);

      // randomized key stream
      for (int it = 0; it < 400; it++) begin
         r = $urandom_range(0, 99);
         if (r < 55)      k = $urandom_range(0, 9);
         else if (r < 65) k = 10;
         else if (r < 73) k = 13;
         else if (r < 80) k = 11;
         else if (r < 88) k = 14;
         else if (r < 91) k = 12;
         else             k = 15;
         press(k);
         if (k != 15 && $urandom_range(0, 9) == 0)
            wait_conv();
         else
            idle($urandom_range(0, 2));
      end

      // reset during a conversion
      press(5);
      idle(5);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      check_reset();
      rst = 1'b0;
      idle(2);
      check("post_rst_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
